// File: rtl/seq_slice_adder_pkg.sv
// seq_slice_adder_pkg: shared FSM encodings and default ALU widths
package seq_slice_adder_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE_W = 16;
endpackage

// File: rtl/seq_slice_adder_slice.sv
// slice_adder: combinational W-bit adder slice with carry in/out (x, y, cin -> s, cout)
module slice_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
endmodule

// File: rtl/seq_slice_adder.sv
// seq_slice_adder: multi-cycle adder, one SLICE_W slice per clock; start/busy/done handshake, sum/carry/overflow held until next start
module seq_slice_adder
  import seq_slice_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int CW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb;
  logic ic, cout;
  logic [SLICE_W-1:0] xs, ys, s;
  assign xs = ra[cnt*SLICE_W +: SLICE_W];
  assign ys = rb[cnt*SLICE_W +: SLICE_W];
  assign busy = state == RUN;
  assign done = state == DONE;
  slice_adder #(.W(SLICE_W)) u_slice (.x(xs), .y(ys), .cin(ic), .s(s), .cout(cout));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ic <= 1'b0;
      ra <= '0;
      rb <= '0;
      sum <= '0;
      carry <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= b;
          cnt <= '0;
          ic <= 1'b0;
          carry <= 1'b0;
          overflow <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          sum[cnt*SLICE_W +: SLICE_W] <= s;
          ic <= cout;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NUM_SLICES - 1)) begin
            carry <= cout;
            overflow <= (xs[SLICE_W-1] == ys[SLICE_W-1]) && (s[SLICE_W-1] != xs[SLICE_W-1]);
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_slice_adder.sv
// tb_seq_slice_adder: table-driven and randomized self-checking bench for seq_slice_adder
module tb_seq_slice_adder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] a = '0, b = '0, sum;
  logic busy, done, carry, overflow;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [63:0] a, b, s;
    logic c, v;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  seq_slice_adder dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // reference: plain 65-bit addition and the signed-overflow rule
  task automatic model(input logic [63:0] x, y, output logic [63:0] s, output logic c, v);
    logic [64:0] t;
    t = {1'b0, x} + {1'b0, y};
    s = t[63:0];
    c = t[64];
    v = (x[63] == y[63]) && (s[63] != x[63]);
  endtask

  task automatic do_op(input string nm, input logic [63:0] x, y, es, input logic ec, ev);
    int k, nb;
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy1"}, 64'(busy), 64'd1);
    chk({nm, " cy_clr"}, 64'({carry, overflow}), 64'd0);
    k = 0; nb = 0;
    while (!done && k < 20) begin
      if (busy) nb++;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(negedge clk);
      k++;
    end
    chk({nm, " done_seen"}, 64'(done), 64'd1);
    chk({nm, " busy_cycles"}, 64'(nb), 64'd4);
    chk({nm, " sum"}, sum, es);
    chk({nm, " carry"}, 64'(carry), 64'(ec));
    chk({nm, " ovf"}, 64'(overflow), 64'(ev));
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
    chk({nm, " sum_held"}, sum, es);
  endtask

  initial begin
    logic [63:0] x, y, es, xs[3], ys[3];
    logic ec, ev;
    tbl[0] = '{64'h000000000000000A, 64'h0000000000000005, 64'h000000000000000F, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 64'h0000000000000000, 1'b1, 1'b0};
    tbl[2] = '{64'h7FFFFFFFFFFFFFFF, 64'h0000000000000001, 64'h8000000000000000, 1'b0, 1'b1};
    tbl[3] = '{64'hFEDCBA9876543210, 64'h1234567890ABCDEF, 64'h1111111106FFFFFF, 1'b1, 1'b0};
    tbl[4] = '{64'h8000000000000000, 64'h8000000000000000, 64'h0000000000000000, 1'b1, 1'b1};
    tbl[5] = '{64'h0000FFFF0000FFFF, 64'h0000000100000001, 64'h0001000000010000, 1'b0, 1'b0};
    @(negedge clk); @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst sum", sum, 64'd0);
    chk("rst cy_ov", 64'({carry, overflow}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].v);
    for (int i = 0; i < 20; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      if (i % 4 == 0) y[63] = x[63];
      model(x, y, es, ec, ev);
      do_op($sformatf("rnd%0d", i), x, y, es, ec, ev);
    end
    // start held high: an op is accepted every 6 cycles, done at offset 5
    for (int i = 0; i < 3; i++) begin
      xs[i] = {$urandom, $urandom}; ys[i] = {$urandom, $urandom};
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = xs[i]; b = ys[i];
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        if (k == 5) begin
          model(xs[i], ys[i], es, ec, ev);
          chk($sformatf("held%0d done", i), 64'(done), 64'd1);
          chk($sformatf("held%0d sum", i), sum, es);
          chk($sformatf("held%0d carry", i), 64'(carry), 64'(ec));
          chk($sformatf("held%0d ovf", i), 64'(overflow), 64'(ev));
        end else begin
          chk($sformatf("held%0d nodone@%0d", i, k), 64'(done), 64'd0);
        end
      end
    end
    start = 1'b0;
    // reset in the second RUN cycle aborts the op
    repeat (2) @(negedge clk);
    start = 1'b1; a = 64'hFFFFFFFFFFFFFFFF; b = 64'h1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort sum", sum, 64'd0);
    chk("abort carry", 64'(carry), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("abort nodone%0d", k), 64'(done | busy), 64'd0);
    end
    do_op("post_abort", tbl[3].a, tbl[3].b, tbl[3].s, tbl[3].c, tbl[3].v);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_slice_adder.md
Name: seq_slice_adder

Overview:
- Multi-cycle 64-bit adder. It is the addition counterpart of the team's combinational 64-bit subtractor.
- Adds two operands one SLICE_W-bit slice per clock, LSB slice first, with a registered carry between slices.
- Targets ALU paths where a full-width carry chain breaks timing.
- Interface is a start/busy/done handshake; results are held until the next accepted start.

Parameters:
- WIDTH, 64, operand and result width. WIDTH % SLICE_W must be 0.
- SLICE_W, 16, bits added per cycle.
- NUM_SLICES, WIDTH/SLICE_W (localparam), number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  addend A; captured on the accepted start
- b  input  WIDTH  addend B; captured on the accepted start
- busy  output  1  high while computing (RUN)
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  a+b mod 2^WIDTH
- carry  output  1  unsigned carry-out of the MSB
- overflow  output  1  signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum=0, carry=0, overflow=0; slice counter=0; internal carry=0.
- Reset has priority over everything, including mid-RUN. A computation aborted by reset never raises done.
- State IDLE:
  - start=1 at edge E0 captures a and b into operand registers, clears the slice counter and internal carry, goes to RUN.
  - a/b may change after E0 without effect.
- State RUN:
  - Each edge adds slice[cnt] of the operands plus the internal carry via the slice sub-module.
  - Writes the result into sum[cnt*SLICE_W +: SLICE_W], stores cout as the internal carry, increments cnt.
  - busy=1 throughout RUN; start is ignored.
- Last slice (cnt==NUM_SLICES-1) at edge E(NUM_SLICES):
  - carry and overflow are registered from the final slice.
  - State goes to DONE.
- State DONE:
  - done=1 for exactly one cycle, busy=0; start is ignored.
  - Next edge returns to IDLE.
- Latency:
  - busy is high for NUM_SLICES cycles after E0 (4 at default).
  - done is high in the cycle after E(NUM_SLICES).
  - Back-to-back ops: one per NUM_SLICES+2 cycles when start is held high.
- Output validity:
  - sum, carry and overflow are valid from the done cycle until the next accepted start.
  - During RUN, sum is partially updated and not valid.
  - On a new accept, carry and overflow clear to 0.
- Arithmetic:
  - Modulo 2^WIDTH; no saturation.
  - The carry chain spans slices only through the registered internal carry.
- Encoding: FSM is IDLE=2'd0, RUN=2'd1, DONE=2'd2. Unused encoding 2'd3 goes to IDLE.

Decomposition:
- Shared package (or `include header), holding:
  - FSM state localparams (IDLE/RUN/DONE);
  - default WIDTH=64 and SLICE_W=16 constants reused by the ALU.
- Sub-module slice_adder:
  - combinational, parameter W;
  - ports x[W-1:0], y[W-1:0], cin, s[W-1:0], cout;
  - a single {cout,s} = x+y+cin.
- Top module seq_slice_adder holds the FSM, counter, operand, carry and result registers.

Test Plan:
- a=64'h000000000000000A, b=64'h0000000000000005, start one cycle:
  - busy high for 4 cycles, then done pulses once;
  - sum=64'h000000000000000F, carry=0, overflow=0.
- a=64'hFFFFFFFFFFFFFFFF, b=64'h0000000000000001:
  - sum=0, carry=1, overflow=0;
  - verifies the carry ripples through all 4 slices.
- a=64'h7FFFFFFFFFFFFFFF, b=64'h1:
  - sum=64'h8000000000000000, carry=0, overflow=1.
- a=64'hFEDCBA9876543210, b=64'h1234567890ABCDEF:
  - sum=64'h1111111106FFFFFF, carry=1, overflow=0;
  - checks the per-slice carries 0,1,1,1.
- Handshake and reset, in sequence:
  - start held high continuously: done pulses every 6 cycles; a/b changes during RUN do not affect the result.
  - Assert rst in the 2nd RUN cycle: next cycle busy=0, done=0, sum=0, and no done pulse follows.
